weight_loader: RTL and testbench



---
 rtl/tpu_pkg.sv | 13 +
 rtl/wl_skid_buffer.sv | 57 +++++
 rtl/weight_loader.sv | 109 ++++++++++
 tb/tb_weight_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU weight path.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } wl_state_t;

    localparam int WT_ROWS_PER_TILE  = 3;
    localparam int WT_BYTES_PER_WORD = 3;

endpackage

// File: rtl/wl_skid_buffer.sv
// Two-entry output stage for weight_loader: a head register presented to the array plus a skid
// register, filled by the word that returns from the FIFO one cycle after each pop.
module wl_skid_buffer #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  fill_valid,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            count
);

    logic                  head_valid;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] head_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  take;

    // An empty head lets the returning word reach the array in the cycle it arrives.
    assign valid = head_valid | fill_valid;
    assign data  = (head_valid || !fill_valid) ? head_data : fill_data;
    assign take  = valid & ready;
    assign count = {1'b0, head_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk) begin
        // NOTE: the data registers are cleared as well, so the array port reads zero after reset or flush.
        if (!rst_n || flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_data  <= '0;
            skid_data  <= '0;
        end else if (head_valid) begin
            // NOTE: non-blocking assignments so head and skid both shift from their pre-edge values.
            if (take) begin
                if (skid_valid) begin
                    head_data  <= skid_data;
                    skid_valid <= fill_valid;
                    if (fill_valid) skid_data <= fill_data;
                end else begin
                    head_valid <= fill_valid;
                    if (fill_valid) head_data <= fill_data;
                end
            end else if (fill_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= fill_data;
            end
        end else if (fill_valid && !take) begin
            head_valid <= 1'b1;
            head_data  <= fill_data;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Pops 3 x num_tiles words from the weight FIFO and streams them to the systolic array as
// rows of three 8-bit weights over valid/ready, tracking row position and tile/load completion.
module weight_loader
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH    = 24,
    parameter int ROWS_PER_TILE = WT_ROWS_PER_TILE,
    parameter int CNT_WIDTH     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            num_tiles,
    input  logic                  flush,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_empty,
    output logic                  wt_valid,
    input  logic                  wt_ready,
    output logic [DATA_WIDTH-1:0] wt_data,
    output logic [1:0]            wt_row,
    output logic                  wt_last,
    output logic                  busy,
    output logic                  tile_done,
    output logic                  load_done
);

    localparam logic [CNT_WIDTH-1:0] ROWS_C   = CNT_WIDTH'(ROWS_PER_TILE);
    localparam logic [1:0]           LAST_ROW = 2'(ROWS_PER_TILE - 1);

    wl_state_t            state, next_state;
    logic [CNT_WIDTH-1:0] words_left;
    logic [CNT_WIDTH-1:0] accept_left;
    logic [CNT_WIDTH-1:0] load_words;
    logic                 inflight;
    logic                 accept;
    logic [1:0]           buf_count;
    logic [1:0]           occupancy;
    logic [1:0]           occ_after;

    wl_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fill_valid (inflight),
        .fill_data  (rd_data),
        .ready      (wt_ready),
        .valid      (wt_valid),
        .data       (wt_data),
        .count      (buf_count)
    );

    assign accept     = wt_valid & wt_ready;
    assign occupancy  = buf_count + {1'b0, inflight};
    assign occ_after  = occupancy - {1'b0, accept};
    assign load_words = CNT_WIDTH'(num_tiles) * ROWS_C;
    assign wt_last    = (wt_row == LAST_ROW);
    assign tile_done  = accept & wt_last;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // An empty load still passes through FETCH, so its completion lands two cycles after start.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = FETCH;
                FETCH:   if (accept_left == '0 || (accept && accept_left == CNT_WIDTH'(1)))
                             next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default before any condition, so no path can infer a latch.
        rd_en     = 1'b0;
        busy      = (state != IDLE);
        load_done = (state == DONE);
        if (state == FETCH && !flush && !rd_empty && words_left != '0 && occ_after < 2'd2)
            rd_en = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            words_left  <= '0;
            accept_left <= '0;
            inflight    <= 1'b0;
            wt_row      <= '0;
        end else begin
            if (state == IDLE && start) begin
                words_left  <= load_words;
                accept_left <= load_words;
            end else begin
                if (rd_en) words_left <= words_left - CNT_WIDTH'(1);
                if (accept && state == FETCH) accept_left <= accept_left - CNT_WIDTH'(1);
            end
            inflight <= rd_en;
            if (accept) wt_row <= wt_last ? 2'd0 : wt_row + 2'd1;
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: a FIFO model feeds the DUT, expected rows are queued at
// each start, and a negedge monitor compares every accepted row and completion pulse.
module tb_weight_loader;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n, start, flush, wt_ready;
    logic [7:0]   num_tiles;
    logic [W-1:0] rd_data = '0;
    logic         rd_empty = 1'b1;
    logic         rd_en, wt_valid, wt_last, busy, tile_done, load_done;
    logic [W-1:0] wt_data;
    logic [1:0]   wt_row;

    always #5 clk = ~clk;

    weight_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_tiles (num_tiles),
        .flush     (flush),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_empty  (rd_empty),
        .wt_valid  (wt_valid),
        .wt_ready  (wt_ready),
        .wt_data   (wt_data),
        .wt_row    (wt_row),
        .wt_last   (wt_last),
        .busy      (busy),
        .tile_done (tile_done),
        .load_done (load_done)
    );

    typedef struct {
        logic [W-1:0] data;
        int           row;
        bit           last;
    } row_t;

    row_t         exp_q[$];
    logic [W-1:0] ref_q[$];      // FIFO contents in pop order; the last `hidden` entries are not yet visible
    int           hidden = 0;
    int           pops = 0;
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    int           done_count = 0;
    int           acc_total = 0;
    int           final_cyc = 0;
    int           zero_cyc = 0;
    bit           zero_mode = 1'b0;
    int           ready_mode = 1;
    int           ready_phase = 0;
    bit           stall_q = 1'b0;
    logic [W-1:0] stall_data = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model with one-cycle registered read data.
    always @(posedge clk) begin
        if (rd_en && !rd_empty) begin
            rd_data <= ref_q.pop_front();
            pops    <= pops + 1;
        end
        rd_empty <= (ref_q.size() <= hidden);
    end

    // Array-side ready: 0 off, 1 on, 2 pattern 1,0,0, otherwise random.
    initial begin
        wt_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       wt_ready = 1'b0;
                1:       wt_ready = 1'b1;
                2: begin
                    wt_ready    = (ready_phase % 3 == 0);
                    ready_phase = ready_phase + 1;
                end
                default: wt_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        row_t e;
        if (rst_n) begin
            if (rd_en && rd_empty) check("rd_en_while_empty", 1, 0);
            if (stall_q) begin
                check("stall_valid_held", wt_valid, 1);
                check("stall_data_held", wt_data, stall_data);
            end
            if (wt_valid && wt_ready) begin
                acc_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_row", wt_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("row_data", wt_data, e.data);
                    check("row_index", wt_row, e.row);
                    check("row_last", wt_last, e.last);
                    check("tile_done_on_accept", tile_done, e.last);
                    if (exp_q.size() == 0) final_cyc = cyc;
                end
            end else if (tile_done) begin
                check("tile_done_without_accept", tile_done, 0);
            end
            if (load_done) begin
                done_count++;
                check("load_done_cycle", cyc, zero_mode ? zero_cyc + 2 : final_cyc + 1);
            end
            stall_q    = wt_valid && !wt_ready && !flush;
            stall_data = wt_data;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_rd_en"},     rd_en, 0);
        check({tag, "_wt_valid"},  wt_valid, 0);
        check({tag, "_wt_last"},   wt_last, 0);
        check({tag, "_tile_done"}, tile_done, 0);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_wt_data"},   wt_data, 0);
        check({tag, "_wt_row"},    wt_row, 0);
    endtask

    // Called at posedge+1; queues the rows this load must deliver, then pulses start for one cycle.
    task automatic start_load(input int n);
        for (int i = 0; i < 3 * n; i++) begin
            row_t r;
            r.data = ref_q[i];
            r.row  = i % 3;
            r.last = (i % 3 == 2);
            exp_q.push_back(r);
        end
        start     = 1'b1;
        num_tiles = 8'(n);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_load(input string tag, input int nwords, input int p0, input int d0);
        for (int i = 0; i < 400 && done_count == d0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_load_done_once"}, done_count - d0, 1);
        check({tag, "_rows_left"}, exp_q.size(), 0);
        check({tag, "_pop_count"}, pops - p0, nwords);
        check({tag, "_idle_busy"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) ref_q.push_back(W'($urandom));
    endtask

    initial begin
        int p0, d0, a0, n;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; num_tiles = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Two tiles, fixed words, array always ready; first-row latency checked.
        for (int i = 0; i < 6; i++) ref_q.push_back(24'h010203 + 24'h030303 * W'(i));
        ready_mode = 1; p0 = pops; d0 = done_count;
        @(posedge clk);
        #1 start_load(2);
        @(negedge clk);
        check("first_rd_en", rd_en, 1);
        check("busy_after_start", busy, 1);
        check("no_valid_before_data", wt_valid, 0);
        @(negedge clk);
        check("first_wt_valid", wt_valid, 1);
        check("first_wt_data", wt_data, 24'h010203);
        finish_load("basic", 6, p0, d0);

        // Same load, ready toggling 1,0,0.
        for (int i = 0; i < 6; i++) ref_q.push_back(24'h010203 + 24'h030303 * W'(i));
        ready_mode = 2; p0 = pops; d0 = done_count;
        start_load(2);
        finish_load("toggle", 6, p0, d0);

        // FIFO initially empty; three words become visible five cycles apart.
        push_random(3);
        hidden = 3; ready_mode = 1; p0 = pops; d0 = done_count;
        @(posedge clk);
        #1 start_load(1);
        for (int i = 0; i < 3; i++) begin
            repeat (5) @(posedge clk);
            #1 hidden = hidden - 1;
        end
        finish_load("trickle", 3, p0, d0);

        // Random loads with random backpressure.
        ready_mode = 3;
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 5);
            push_random(3 * n);
            p0 = pops; d0 = done_count;
            @(posedge clk);
            #1 start_load(n);
            finish_load("random", 3 * n, p0, d0);
        end

        // Zero tiles.
        ready_mode = 1; p0 = pops; d0 = done_count;
        zero_mode = 1'b1; zero_cyc = cyc;
        start_load(0);
        finish_load("zero", 0, p0, d0);
        zero_mode = 1'b0;

        // Flush after the second accept of a three-tile load, then a one-tile load.
        push_random(9);
        ready_mode = 1; d0 = done_count; a0 = acc_total;
        start_load(3);
        for (int i = 0; i < 100 && acc_total - a0 < 2; i++) @(posedge clk);
        check("flush_reached_two_accepts", acc_total - a0, 2);
        #1 flush = 1'b1; ready_mode = 0;
        @(posedge clk);
        #1 flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle("flush");
        repeat (4) @(posedge clk);
        check("flush_no_load_done", done_count - d0, 0);
        #1 ready_mode = 1; p0 = pops; d0 = done_count;
        start_load(1);
        finish_load("after_flush", 3, p0, d0);
        ref_q.delete();

        // A second start while busy is ignored.
        push_random(12);
        p0 = pops; d0 = done_count;
        @(posedge clk);
        #1 start_load(2);
        @(posedge clk);
        #1 start = 1'b1; num_tiles = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        finish_load("restart_ignored", 6, p0, d0);
        ref_q.delete();

        // Reset in the middle of a load.
        push_random(9);
        d0 = done_count;
        @(posedge clk);
        #1 start_load(3);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_idle("mid_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        ref_q.delete();
        repeat (5) @(posedge clk);
        check("mid_reset_no_load_done", done_count - d0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
